sha_double_hash_ctrl: RTL and testbench

SHA_DOUBLE_HASH_CTRL -- requirements
Module: sha_double_hash_ctrl

---
 rtl/sha_double_hash_ctrl.sv | 128 ++++++++++++
 tb/tb_sha_double_hash_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_double_hash_ctrl.sv
// Sequences an external SHA-256 compression core through the three blocks of a double hash
// of an 80-byte header (B1, B2, final digest); only word reordering and padding are done here.
module sha_double_hash_ctrl #(
  parameter logic [255:0] SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [639:0] header,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic         core_first_state,
  output logic [511:0] core_message_block,
  output logic [255:0] core_initial_state,
  input  logic         core_status,
  input  logic [255:0] core_hash,
  input  logic         core_valid_block
);

  typedef enum logic [2:0] {
    IDLE, B1_ISSUE, B1_WAIT, B2_ISSUE, B2_WAIT, D_ISSUE, D_WAIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   hdr_tail_q, hdr_tail_d;
  logic [511:0]   msg_q, msg_d;
  logic [255:0]   iv_q, iv_d;
  logic [255:0]   digest_q, digest_d;
  logic [255:0]   hash_rev;

  // Core reports H0 in the top word but takes its chaining state with H0 in the bottom word.
  always_comb begin
    hash_rev = '0;
    for (int i = 0; i < 8; i++) begin
      hash_rev[32*i +: 32] = core_hash[32*(7-i) +: 32];
    end
  end

  always_comb begin
    state_d          = state_q;
    hdr_tail_d       = hdr_tail_q;
    msg_d            = msg_q;
    iv_d             = iv_q;
    digest_d         = digest_q;
    core_first_state = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = B1_ISSUE;
          // The first 64 header bytes go straight into the message register; only the tail is kept.
          hdr_tail_d = header[127:0];
          msg_d      = header[639:128];
          iv_d       = SHA_IV;
        end
      end
      B1_ISSUE: begin
        if (core_status) begin
          core_first_state = 1'b1;
          state_d          = B1_WAIT;
        end
      end
      B1_WAIT: begin
        if (core_valid_block) begin
          state_d = B2_ISSUE;
          msg_d   = {hdr_tail_q, 32'h80000000, 288'b0, 64'd640};
          iv_d    = hash_rev;
        end
      end
      B2_ISSUE: begin
        if (core_status) begin
          core_first_state = 1'b1;
          state_d          = B2_WAIT;
        end
      end
      B2_WAIT: begin
        if (core_valid_block) begin
          state_d = D_ISSUE;
          msg_d   = {core_hash, 32'h80000000, 160'b0, 64'd256};
          iv_d    = SHA_IV;
        end
      end
      D_ISSUE: begin
        if (core_status) begin
          core_first_state = 1'b1;
          state_d          = D_WAIT;
        end
      end
      D_WAIT: begin
        if (core_valid_block) begin
          // Loaded on the edge into DONE so the new digest is already visible while done is high.
          state_d  = DONE;
          digest_d = core_hash;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hdr_tail_q <= '0;
      msg_q      <= '0;
      iv_q       <= '0;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      hdr_tail_q <= hdr_tail_d;
      msg_q      <= msg_d;
      iv_q       <= iv_d;
      digest_q   <= digest_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign digest             = digest_q;
  assign core_message_block = msg_q;
  assign core_initial_state = iv_q;

endmodule

// File: tb/tb_sha_double_hash_ctrl.sv
// Directed bench for sha_double_hash_ctrl with a behavioural SHA-256 compression core
// and an independent padded double-SHA-256 reference.
module tb_sha_double_hash_ctrl;

  localparam int CORE_LAT = 20;
  localparam logic [255:0] IV_LE = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
      256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
      32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [255:0] GEN_DIG =
      256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [639:0] header = '0;
  logic         busy, done;
  logic [255:0] digest;
  logic         core_first_state;
  logic [511:0] core_message_block;
  logic [255:0] core_initial_state;
  logic         core_status = 1'b1;
  logic [255:0] core_hash = '0;
  logic         core_valid_block = 1'b0;

  int total = 0;
  int bad = 0;
  int issue_cnt = 0;
  int done_cnt = 0;
  int phase = 0;
  bit stall_b2 = 1'b0;
  logic [639:0]  cur_hdr = '0;
  logic [255:0]  last_hash = '0;
  int            cm_ph;
  logic [511:0]  cm_msg, cm_exp_msg;
  logic [255:0]  cm_iv, cm_exp_iv;
  logic [1023:0] cm_pad;

  sha_double_hash_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .header(header),
    .busy(busy), .done(done), .digest(digest),
    .core_first_state(core_first_state), .core_message_block(core_message_block),
    .core_initial_state(core_initial_state), .core_status(core_status),
    .core_hash(core_hash), .core_valid_block(core_valid_block)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Standard SHA-256 compression; state has H0 in the top word.
  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  function automatic logic [255:0] rev_words(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*(7-i) +: 32];
    return r;
  endfunction

  function automatic logic [1023:0] pad_hdr(input logic [639:0] m);
    logic [1023:0] b;
    b = {m, 384'b0};
    b[383] = 1'b1;
    b[63:0] = 64'd640;
    return b;
  endfunction

  function automatic logic [511:0] pad_dig(input logic [255:0] m);
    logic [511:0] b;
    b = {m, 256'b0};
    b[255] = 1'b1;
    b[63:0] = 64'd256;
    return b;
  endfunction

  function automatic logic [255:0] ref_sha256d(input logic [639:0] m);
    logic [1023:0] p;
    logic [255:0]  h;
    p = pad_hdr(m);
    h = sha_compress(rev_words(IV_LE), p[1023:512]);
    h = sha_compress(h, p[511:0]);
    return sha_compress(rev_words(IV_LE), pad_dig(h));
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Behavioural core: checks operands on each start pulse, then returns the compression result.
  always begin
    @(negedge clk);
    if (reset === 1'b0 && core_first_state === 1'b1) begin
      cm_ph = phase;
      phase = (phase == 2) ? 0 : phase + 1;
      cm_msg = core_message_block;
      cm_iv = core_initial_state;
      cm_pad = pad_hdr(cur_hdr);
      case (cm_ph)
        0:       begin cm_exp_msg = cm_pad[1023:512]; cm_exp_iv = IV_LE; end
        1:       begin cm_exp_msg = cm_pad[511:0]; cm_exp_iv = rev_words(last_hash); end
        default: begin cm_exp_msg = pad_dig(last_hash); cm_exp_iv = IV_LE; end
      endcase
      check("issue message", cm_msg, cm_exp_msg);
      check("issue chaining", 512'(cm_iv), 512'(cm_exp_iv));
      issue_cnt++;
      @(posedge clk); #1;
      core_status = 1'b0;
      core_valid_block = 1'b0;
      repeat (CORE_LAT) @(posedge clk);
      #1;
      if (busy === 1'b1) begin
        check("message held", core_message_block, cm_msg);
        check("chaining held", 512'(core_initial_state), 512'(cm_iv));
      end
      last_hash = sha_compress(rev_words(cm_iv), cm_msg);
      core_hash = last_hash;
      core_valid_block = 1'b1;
      if (stall_b2 && cm_ph == 0) begin
        repeat (10) begin
          @(negedge clk);
          check("stalled no start pulse", 512'(core_first_state), 512'(1'b0));
          check("stalled busy", 512'(busy), 512'(1'b1));
        end
        @(posedge clk); #1;
      end
      core_status = 1'b1;
    end
  end

  task automatic pulse_start(input logic [639:0] h);
    cur_hdr = h;
    header = h;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    header = ~h;
  endtask

  task automatic wait_issues(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (issue_cnt < n && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check(tag, 512'(issue_cnt >= n), 512'(1'b1));
  endtask

  task automatic wait_done(input string tag, input logic [255:0] exp);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 220) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, " done within bound"}, 512'(seen), 512'(1'b1));
    check({tag, " digest"}, 512'(digest), 512'(exp));
    check({tag, " busy in DONE"}, 512'(busy), 512'(1'b1));
    @(negedge clk);
    check({tag, " done single cycle"}, 512'(done), 512'(1'b0));
    check({tag, " digest held"}, 512'(digest), 512'(exp));
  endtask

  initial begin
    int n, d0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 512'(busy), 512'(1'b0));
    check("reset done", 512'(done), 512'(1'b0));
    check("reset first_state", 512'(core_first_state), 512'(1'b0));
    check("reset digest", 512'(digest), 512'(0));
    check("reset message", core_message_block, 512'(0));
    check("reset chaining", 512'(core_initial_state), 512'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after release", 512'(busy), 512'(1'b0));

    // Genesis header
    pulse_start(GEN_HDR);
    @(negedge clk);
    check("busy after start", 512'(busy), 512'(1'b1));
    wait_done("genesis", GEN_DIG);

    // Core not ready for 10 cycles before B2
    stall_b2 = 1'b1;
    pulse_start(GEN_HDR);
    wait_done("stall", GEN_DIG);
    stall_b2 = 1'b0;

    // start during B2_WAIT must be ignored
    n = issue_cnt + 2;
    #1 d0 = done_cnt;
    pulse_start(GEN_HDR);
    wait_issues(n, "reach B2");
    @(posedge clk); #1;
    start = 1'b1;
    header = 640'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored start", GEN_DIG);
    repeat (30) @(negedge clk);
    #1;
    check("ignored start one done", 512'(done_cnt), 512'(d0 + 1));
    check("ignored start no extra issue", 512'(issue_cnt), 512'(n + 1));
    check("ignored start idle", 512'(busy), 512'(1'b0));

    // Reset five cycles into D_WAIT
    n = issue_cnt + 3;
    d0 = done_cnt;
    pulse_start(GEN_HDR);
    wait_issues(n, "reach D");
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    phase = 0;
    @(negedge clk);
    check("abort busy", 512'(busy), 512'(1'b0));
    check("abort digest", 512'(digest), 512'(0));
    check("abort done", 512'(done), 512'(1'b0));
    check("abort first_state", 512'(core_first_state), 512'(1'b0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort no done", 512'(done_cnt), 512'(d0));
    check("abort stays idle", 512'(busy), 512'(1'b0));
    pulse_start(GEN_HDR);
    wait_done("after abort", GEN_DIG);

    // Back-to-back: genesis then all-zero header
    #1 d0 = done_cnt;
    pulse_start(GEN_HDR);
    wait_done("b2b genesis", GEN_DIG);
    pulse_start(640'b0);
    wait_done("b2b zero", ref_sha256d(640'b0));
    #1;
    check("b2b two dones", 512'(done_cnt), 512'(d0 + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
